// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX core among NUM_REQ byte requesters.
// Build option UART_TX_ARB_FIXED_PRIO_EN selects fixed lowest-index priority; default is round-robin.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned BUSY_TIMEOUT = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_start,
   output logic [WIDTH-1:0]           tx_data,
   input  logic                       tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       arb_busy,
   output logic                       err_timeout
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned CW  = $clog2(BUSY_TIMEOUT);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, HOLD} state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_hold;
   logic [IDW-1:0]   r_grant_id;
   logic [IDW-1:0]   w_gnt;
   logic [IDW-1:0]   w_idx;
   logic [CW-1:0]    r_cnt;
   logic             r_tx_start;
   logic             r_err_timeout;
   logic             w_found;
   logic             w_accept;
   logic             w_timeout;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
   logic [IDW-1:0]   r_rr_ptr;
`endif

   // Winner search: first valid requester scanning upward from the start index.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
         w_idx = IDW'(k);
`else
         w_idx = IDW'((32'(r_rr_ptr) + k) % NUM_REQ);
`endif
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = w_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      req_ready = '0;
      w_accept  = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found && !tx_busy) begin
               req_ready[w_gnt] = 1'b1;
               w_accept         = 1'b1;
               w_next           = LAUNCH;
            end
         end
         LAUNCH: w_next = WAIT_BUSY;
         WAIT_BUSY: begin
            if (tx_busy) begin
               w_next = HOLD;
            end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
               w_timeout = 1'b1;
               w_next    = IDLE;
            end
         end
         HOLD: begin
            if (!tx_busy) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold        <= '0;
         r_grant_id    <= '0;
         r_cnt         <= '0;
         r_tx_start    <= 1'b0;
         r_err_timeout <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
         r_rr_ptr      <= '0;
`endif
      end else begin
         r_tx_start    <= w_accept;
         r_err_timeout <= w_timeout;
         if (w_accept) begin
            r_hold     <= req_data[w_gnt*WIDTH +: WIDTH];
            r_grant_id <= w_gnt;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            r_rr_ptr   <= (w_gnt == IDW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
`endif
         end
         if (r_state == LAUNCH)                     r_cnt <= '0;
         else if (r_state == WAIT_BUSY && !tx_busy) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tx_start    = r_tx_start;
   assign tx_data     = r_hold;
   assign grant_id    = r_grant_id;
   assign arb_busy    = (r_state != IDLE);
   assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus multi-cycle sequences.
// Expectations follow UART_TX_ARB_FIXED_PRIO_EN when it is defined for the build.
module tb_uart_tx_arbiter;

   localparam int unsigned FRAME = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        arb_busy;
   logic        err_timeout;

   logic        core_en  = 1'b0;
   logic        drv_busy = 1'b0;
   int unsigned core_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int n_st;
   int gap;
   int errs;
   int bad_hold;
   logic [7:0] got_d [5];
   logic [1:0] got_g [5];

   typedef struct packed {
      logic [3:0]  v;
      logic [31:0] d;
      logic        b;
      logic [3:0]  rdy;
      logic        st;
      logic [7:0]  txd;
      logic [1:0]  gid;
      logic        ab;
      logic        er;
   } vec_t;
   vec_t tbl [15];

   always #5 clk = ~clk;

   // Behavioural TX core: busy for FRAME cycles starting the cycle after tx_start.
   assign tx_busy = core_en ? (core_cnt != 0) : drv_busy;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   core_cnt <= 0;
      else if (core_cnt != 0)       core_cnt <= core_cnt - 1;
      else if (core_en && tx_start) core_cnt <= FRAME;
   end

   uart_tx_arbiter #(.NUM_REQ(4), .WIDTH(8), .BUSY_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .grant_id(grant_id), .arb_busy(arb_busy), .err_timeout(err_timeout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      req_data  = '0;
      drv_busy  = 1'b0;
      core_en   = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      //            valid    data          busy  ready    st    txd    gid   ab    er
      tbl[0]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
      tbl[1]  = '{4'b0100, 32'h00A50000, 1'b0, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
      tbl[2]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2, 1'b1, 1'b0};
      tbl[3]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1, 1'b0};
      tbl[4]  = '{4'b0100, 32'h005A0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1, 1'b0};
      tbl[5]  = '{4'b0100, 32'h005A0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1, 1'b0};
      tbl[6]  = '{4'b0100, 32'h005A0000, 1'b0, 4'b0100, 1'b0, 8'hA5, 2'd2, 1'b0, 1'b0};
      tbl[7]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 8'h5A, 2'd2, 1'b1, 1'b0};
      tbl[8]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b1, 1'b0};
      tbl[9]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b1, 1'b0};
      tbl[10] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b0, 1'b0};
      tbl[11] = '{4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b0, 1'b0};
      tbl[12] = '{4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b0, 1'b0};
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      tbl[13] = '{4'b1111, 32'h13121110, 1'b0, 4'b0001, 1'b0, 8'h5A, 2'd2, 1'b0, 1'b0};
      tbl[14] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0};
`else
      tbl[13] = '{4'b1111, 32'h13121110, 1'b0, 4'b1000, 1'b0, 8'h5A, 2'd2, 1'b0, 1'b0};
      tbl[14] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 8'h13, 2'd3, 1'b1, 1'b0};
`endif

      // Per-cycle vectors: single request, mid-frame data change, busy held in IDLE.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         cyc();
         req_valid = tbl[i].v;
         req_data  = tbl[i].d;
         drv_busy  = tbl[i].b;
         #1;
         chk($sformatf("row%0d req_ready", i),   32'(req_ready),   32'(tbl[i].rdy));
         chk($sformatf("row%0d tx_start", i),    32'(tx_start),    32'(tbl[i].st));
         chk($sformatf("row%0d tx_data", i),     32'(tx_data),     32'(tbl[i].txd));
         chk($sformatf("row%0d grant_id", i),    32'(grant_id),    32'(tbl[i].gid));
         chk($sformatf("row%0d arb_busy", i),    32'(arb_busy),    32'(tbl[i].ab));
         chk($sformatf("row%0d err_timeout", i), 32'(err_timeout), 32'(tbl[i].er));
      end

      // All requesters continuously valid: launch order.
      do_reset();
      core_en   = 1'b1;
      req_valid = 4'b1111;
      req_data  = 32'h13121110;
      for (int i = 0; i < 5; i++) begin
         got_d[i] = 'x;
         got_g[i] = 'x;
      end
      n_st = 0;
      for (int c = 0; c < 200 && n_st < 5; c++) begin
         cyc();
         #1;
         if (tx_start) begin
            got_d[n_st] = tx_data;
            got_g[n_st] = grant_id;
            n_st++;
         end
      end
      chk("rr_starts_seen", 32'(n_st), 32'd5);
      for (int i = 0; i < 5; i++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
         chk($sformatf("order%0d data", i),  32'(got_d[i]), 32'h10);
         chk($sformatf("order%0d grant", i), 32'(got_g[i]), 32'd0);
`else
         chk($sformatf("order%0d data", i),  32'(got_d[i]), 32'h10 + 32'(i % 4));
         chk($sformatf("order%0d grant", i), 32'(got_g[i]), 32'(i % 4));
`endif
      end

      // Requester 1 keeps valid and changes data mid-frame.
      do_reset();
      core_en = 1'b1;
      cyc();
      req_valid = 4'b0010;
      req_data  = 32'h00003C00;
      #1;
      chk("hold first_ready", 32'(req_ready), 32'b0010);
      gap      = 0;
      bad_hold = 0;
      for (int c = 0; c < 50; c++) begin
         cyc();
         if (gap == 0) req_data = 32'h0000C300;
         #1;
         gap++;
         if (req_ready != 4'b0000) break;
         if (tx_data != 8'h3C) bad_hold++;
      end
      chk("hold gap", 32'(gap), 32'(FRAME + 3));
      chk("hold second_ready", 32'(req_ready), 32'b0010);
      chk("hold tx_data_stable", 32'(bad_hold), 32'd0);
      chk("hold tx_data_at_regrant", 32'(tx_data), 32'h3C);
      cyc();
      #1;
      chk("hold new_start", 32'(tx_start), 32'd1);
      chk("hold new_data", 32'(tx_data), 32'hC3);

      // tx_busy never rises: timeout drop and re-grant.
      do_reset();
      cyc();
      req_valid = 4'b0011;
      req_data  = 32'h0000BBAA;
      #1;
      chk("tmo first_ready", 32'(req_ready), 32'b0001);
      cyc();
      #1;
      chk("tmo launch", 32'(tx_start), 32'd1);
      errs = 0;
      for (int c = 0; c < 4; c++) begin
         cyc();
         #1;
         if (err_timeout) errs++;
      end
      chk("tmo early_err", 32'(errs), 32'd0);
      cyc();
      #1;
      chk("tmo err_pulse", 32'(err_timeout), 32'd1);
      chk("tmo arb_idle", 32'(arb_busy), 32'd0);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      chk("tmo next_ready", 32'(req_ready), 32'b0001);
`else
      chk("tmo next_ready", 32'(req_ready), 32'b0010);
`endif
      cyc();
      #1;
      chk("tmo err_single", 32'(err_timeout), 32'd0);
      chk("tmo relaunch", 32'(tx_start), 32'd1);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      chk("tmo next_grant", 32'(grant_id), 32'd0);
      chk("tmo next_data", 32'(tx_data), 32'hAA);
`else
      chk("tmo next_grant", 32'(grant_id), 32'd1);
      chk("tmo next_data", 32'(tx_data), 32'hBB);
`endif

      // Reset asserted during HOLD.
      do_reset();
      core_en = 1'b1;
      cyc();
      req_valid = 4'b0100;
      req_data  = 32'h00770000;
      #1;
      chk("rst grant_ready", 32'(req_ready), 32'b0100);
      repeat (3) cyc();
      #1;
      chk("rst in_hold_busy", 32'(arb_busy), 32'd1);
      chk("rst in_hold_data", 32'(tx_data), 32'h77);
      chk("rst in_hold_core", 32'(tx_busy), 32'd1);
      req_valid = 4'b0000;
      rst_n     = 1'b0;
      #1;
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst tx_start", 32'(tx_start), 32'd0);
      chk("rst tx_data", 32'(tx_data), 32'd0);
      chk("rst grant_id", 32'(grant_id), 32'd0);
      chk("rst arb_busy", 32'(arb_busy), 32'd0);
      chk("rst err_timeout", 32'(err_timeout), 32'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 4'b1111;
      req_data  = 32'h13121110;
      #1;
      chk("rst first_ready", 32'(req_ready), 32'b0001);
      cyc();
      #1;
      chk("rst first_start", 32'(tx_start), 32'd1);
      chk("rst first_grant", 32'(grant_id), 32'd0);
      chk("rst first_data", 32'(tx_data), 32'h10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmit core among NUM_REQ byte requesters. It accepts one byte at a time over a valid/ready handshake and latches it into a holding register. It then launches the byte with a one-cycle tx_start pulse and holds tx_data stable until the core drops tx_busy. It sits between client blocks (register bridge, debug printer, etc.) and the TX core, which takes tx_start, tx_data and tx_busy.

## Interface
- NUM_REQ, 4: number of requesters, minimum 2.
- WIDTH, 8: data bits per frame; must match the TX core.
- BUSY_TIMEOUT, 4: cycles allowed after tx_start for tx_busy to rise, minimum 2.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte-available flag.
- req_data  in  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot acceptance strobe; a transfer occurs when valid and ready are both high on a rising edge.
- tx_start  out  1  one-cycle launch pulse to the TX core.
- tx_data  out  WIDTH  byte to the TX core, driven from the holding register.
- tx_busy  in  1  busy flag from the TX core.
- grant_id  out  $clog2(NUM_REQ)  index of the requester whose byte is in flight.
- arb_busy  out  1  high whenever state is not IDLE.
- err_timeout  out  1  one-cycle pulse when tx_busy fails to rise.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, HOLD.
- IDLE
  - If any req_valid is high and tx_busy is 0, pick the winner g by round-robin starting at rr_ptr.
  - req_ready[g]=1 combinationally in that cycle.
  - At the edge: hold_reg<=req_data[g], grant_id<=g, rr_ptr<=(g+1) mod NUM_REQ, go to LAUNCH.
  - If tx_busy=1, no grant is given; all req_ready stay 0.
- LAUNCH: tx_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY
  - If tx_busy=1, go to HOLD.
  - Otherwise increment the counter. When it reaches BUSY_TIMEOUT-1 with tx_busy still 0: pulse err_timeout, drop the byte, go to IDLE.
- HOLD: wait for tx_busy=0, then go to IDLE.
- req_ready is 0 in every state except IDLE; at most one bit is ever high.
- tx_data = hold_reg at all times. It changes only at an acceptance edge, never while the core can still sample it.
- A requester that deasserts req_valid before being granted loses nothing; no state is kept per requester.
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant_id=0, arb_busy=0, err_timeout=0, rr_ptr=0, state IDLE. Reset mid-frame abandons the byte without a pulse.

## Timing
- Acceptance edge at cycle T; tx_start high in cycle T+1; the TX core's tx_busy is expected high in cycle T+2.
- Minimum gap between acceptances: frame duration plus 3 cycles (LAUNCH, the first WAIT_BUSY cycle, and the cycle observing tx_busy=0).
- tx_start and err_timeout are registered outputs; req_ready is combinational from state, req_valid, rr_ptr and tx_busy.
- Round-robin fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 frames.
- rr_ptr is not advanced on a timeout drop, because it already advanced at acceptance.

## Configuration
- UART_TX_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins; rr_ptr is removed and grant is independent of history.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Single request: req_valid[2]=1 with data 0xA5.
  - req_ready[2] pulses one cycle; tx_start is high at T+1; grant_id=2; tx_data=0xA5 until tx_busy falls.
- All four requesters continuously valid with data 0x10..0x13.
  - Round-robin build: transmitted order 0x10,0x11,0x12,0x13,0x10.
  - FIXED_PRIO build: 0x10 repeated.
- Requester 1 holds req_valid through a frame and changes req_data mid-frame.
  - tx_data stays at the accepted value.
  - No second req_ready until tx_busy=0 is observed.
- Busy never rises (tx_busy tied to 0), BUSY_TIMEOUT=4.
  - err_timeout pulses once, 4 cycles after WAIT_BUSY entry; the arbiter returns to IDLE and grants the next requester.
- tx_busy already high in IDLE while req_valid=4'b1111: all req_ready stay 0 until tx_busy=0.
- rst_n asserted during HOLD: all outputs go to their reset values immediately; after release, the first grant goes to requester 0.
